// File: rtl/transfer_center.sv
// transfer_center: serial-to-parallel receive stage.
// Shifts bits in MSB-first while the sender qualifies them, latches every
// completed byte into dataBuffer and reports its state to the local scanners.
module transfer_center (
  input  logic       clk,
  input  logic       rst,
  input  logic       dataIn,
  input  logic       readyForTransferIn,
  output logic [2:0] byteCounter,
  output logic [7:0] byteIn,
  output logic       readyForTransferOut,
  output logic [1:0] localScannerOut,
  output logic [7:0] dataBuffer
);

  // State codes double as the local scanner code, so the output is a plain decode.
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RECEIVE = 2'b01;
  localparam logic [1:0] DONE    = 2'b10;
  localparam logic [1:0] PAUSE   = 2'b11;

  logic [1:0] stateReg, stateNext;
  logic [2:0] countReg, countNext;
  logic [7:0] shiftReg, shiftNext;
  logic [7:0] bufferReg, bufferNext;
  logic       acceptBit;
  logic [7:0] shifted;

  // A bit is taken whenever the sender qualifies it and we are not in the DONE slot.
  always_comb begin
    acceptBit = readyForTransferIn && (stateReg != DONE);
    shifted   = {shiftReg[6:0], dataIn};
  end

  // Next-state and datapath decisions; everything holds unless changed below.
  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    shiftNext  = shiftReg;
    bufferNext = bufferReg;
    case (stateReg)
      DONE: begin
        // One-cycle completion slot; inputs are ignored here.
        stateNext = IDLE;
      end
      IDLE, RECEIVE, PAUSE: begin
        if (acceptBit) begin
          shiftNext = shifted;
          if (countReg == 3'd7) begin
            bufferNext = shifted;
            countNext  = 3'd0;
            stateNext  = DONE;
          end else begin
            countNext = countReg + 3'd1;
            stateNext = RECEIVE;
          end
        end else if (stateReg == RECEIVE) begin
          // Sender stalled mid-byte: keep the partial byte and wait.
          stateNext = PAUSE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial byte and the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      countReg  <= 3'd0;
      shiftReg  <= 8'h00;
      bufferReg <= 8'h00;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      shiftReg  <= shiftNext;
      bufferReg <= bufferNext;
    end
  end

  // Outputs: registers straight out, readiness decoded from state only.
  always_comb begin
    byteCounter         = countReg;
    byteIn              = shiftReg;
    dataBuffer          = bufferReg;
    localScannerOut     = stateReg;
    readyForTransferOut = (stateReg != DONE);
  end

endmodule

// File: tb/tb_transfer_center.sv
// Bench for transfer_center: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural byte-assembly model.
module tb_transfer_center;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dataIn = 1'b0;
  logic       readyForTransferIn = 1'b0;
  logic [2:0] byteCounter;
  logic [7:0] byteIn;
  logic       readyForTransferOut;
  logic [1:0] localScannerOut;
  logic [7:0] dataBuffer;

  transfer_center dut (
    .clk                (clk),
    .rst                (rst),
    .dataIn             (dataIn),
    .readyForTransferIn (readyForTransferIn),
    .byteCounter        (byteCounter),
    .byteIn             (byteIn),
    .readyForTransferOut(readyForTransferOut),
    .localScannerOut    (localScannerOut),
    .dataBuffer         (dataBuffer)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: bits received so far, value assembled so far, last byte,
  // and whether the one-cycle completion slot or a stall is in progress.
  int  bitsSoFar = 0;
  int  partial   = 0;
  int  lastByte  = 0;
  bit  inDone    = 0;
  bit  stalled   = 0;
  bit  midByte   = 0;
  int  cycle     = 0;
  int  lastDoneCycle = -1;

  function automatic logic [1:0] expScanner();
    if (inDone) return 2'b10;
    if (stalled) return 2'b11;
    if (midByte) return 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset();
    bitsSoFar = 0; partial = 0; lastByte = 0;
    inDone = 0; stalled = 0; midByte = 0;
  endtask

  task automatic modelEdge(input bit rdy, input bit din);
    if (inDone) begin
      inDone = 0; stalled = 0; midByte = 0;
    end else if (rdy) begin
      partial = (partial * 2 + din) % 256;
      bitsSoFar = bitsSoFar + 1;
      stalled = 0;
      if (bitsSoFar == 8) begin
        bitsSoFar = 0;
        lastByte = partial;
        inDone = 1;
        midByte = 0;
      end else begin
        midByte = 1;
      end
    end else if (midByte && !stalled) begin
      stalled = 1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".byteCounter"}, {5'd0, byteCounter}, 8'(bitsSoFar));
    check({tag, ".byteIn"}, byteIn, 8'(partial));
    check({tag, ".dataBuffer"}, dataBuffer, 8'(lastByte));
    check({tag, ".scanner"}, {6'd0, localScannerOut}, {6'd0, expScanner()});
    check({tag, ".ready"}, {7'd0, readyForTransferOut}, {7'd0, !inDone});
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic step(input string tag, input bit rdy, input bit din);
    readyForTransferIn = rdy;
    dataIn = din;
    @(posedge clk);
    cycle++;
    if (rst) modelReset();
    else modelEdge(rdy, din);
    #1;
    checkAll(tag);
    if (inDone) begin
      if (tag == "b2b" && lastDoneCycle >= 0)
        check("b2b.spacing", 8'(cycle - lastDoneCycle), 8'd9);
      lastDoneCycle = cycle;
    end
    $display("cyc=%0d %s rdy=%0b din=%0b cnt=%0d byteIn=%02h buf=%02h scan=%02b rdyOut=%0b",
             cycle, tag, rdy, din, byteCounter, byteIn, dataBuffer, localScannerOut,
             readyForTransferOut);
  endtask

  task automatic sendByte(input string tag, input logic [7:0] value);
    for (int i = 7; i >= 0; i--) step(tag, 1'b1, value[i]);
  endtask

  initial begin
    logic [7:0] v;
    modelReset();
    #1;
    checkAll("reset.initial");
    step("reset.hold", 1'b1, 1'b1);
    step("reset.hold", 1'b1, 1'b0);
    #2 rst = 1'b0;

    // Single byte A5 followed by its DONE slot and return to idle.
    sendByte("a5", 8'hA5);
    step("a5.after", 1'b0, 1'b0);
    step("a5.idle", 1'b0, 1'b1);

    // Pause: three bits of 3C, four-cycle gap with noisy dataIn, then the rest.
    v = 8'h3C;
    for (int i = 7; i >= 5; i--) step("pause.head", 1'b1, v[i]);
    for (int i = 0; i < 4; i++) step("pause.gap", 1'b0, i[0]);
    for (int i = 4; i >= 0; i--) step("pause.tail", 1'b1, v[i]);
    step("pause.done", 1'b0, 1'b0);

    // Reset mid-byte, asserted asynchronously between edges.
    v = 8'hC3;
    for (int i = 7; i >= 3; i--) step("midrst.bits", 1'b1, v[i]);
    #2 rst = 1'b1;
    #1 modelReset();
    checkAll("midrst.async");
    step("midrst.hold", 1'b1, 1'b1);
    #2 rst = 1'b0;
    sendByte("ff", 8'hFF);
    step("ff.done", 1'b0, 1'b0);

    // Back-to-back 81 then 7E; qualifier low only across DONE, dataIn toggling there.
    lastDoneCycle = -1;
    sendByte("b2b", 8'h81);
    step("b2b", 1'b0, 1'b1);
    sendByte("b2b", 8'h7E);
    step("b2b.end", 1'b0, 1'b0);

    // Qualifier held high across DONE: that bit must be ignored.
    sendByte("hold", 8'h5A);
    step("hold.done", 1'b1, 1'b1);
    step("hold.idle", 1'b0, 1'b0);

    // Idle noise.
    for (int i = 0; i < 10; i++) step("noise", 1'b0, i[0]);

    // Random traffic with occasional stalls and rare async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 modelReset();
        checkAll("rand.rst");
        #1 rst = 1'b0;
      end
      step("rand", ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
